// File: rtl/approx_mac_accumulator_pkg.sv
// Shared types and helpers for the approximate-MAC accumulator stage.
package approx_mac_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 8;
    localparam int MAX_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] value,
        input logic [MAX_CNT_W-1:0] max_value
    );
        return (value >= max_value) ? max_value : value + 1'b1;
    endfunction

endpackage

// File: rtl/approx_mac_accumulator_if.sv
// Product-in / packet-result-out handshake bundle for approx_mac_accumulator.
interface approx_mac_accumulator_if
    import approx_mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/approx_mac_accumulator_sat_counter.sv
// Saturating term counter: clear has priority over enable; sat_hit flags an
// increment attempted while already at the maximum.
module approx_mac_sat_counter
    import approx_mac_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count_next,
    output logic             sat_hit
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    assign sat_hit    = en && (count_reg == CNT_MAX);
    assign count_next = en ? CNT_W'(sat_inc(MAX_CNT_W'(count_reg), MAX_CNT_W'(CNT_MAX)))
                           : count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/approx_mac_accumulator.sv
// Packet dot-product accumulator for approximate-multiplier products.
// Optional per-term bias compensation enabled by `define APPROX_BIAS_COMP_EN.
module approx_mac_accumulator
    import approx_mac_pkg::*;
#(
    parameter int                PROD_W = DEF_PROD_W,
    parameter int                ACC_W  = DEF_ACC_W,
    parameter int                CNT_W  = DEF_CNT_W,
    parameter logic [PROD_W-1:0] BIAS   = '0
) (
    input  logic clk,
    input  logic rst_n,
    approx_mac_accumulator_if.slave bus
);
    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;
    logic [ACC_W-1:0] sum_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_out_reg;
    logic             valid_reg;

    logic             accept;
    logic [ACC_W:0]   term;
    logic [ACC_W+1:0] sum_wide;
    logic             add_carry;
    logic             sat_hit;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;

    assign accept = bus.in_valid && (state_reg != DONE);

`ifdef APPROX_BIAS_COMP_EN
    assign term = (ACC_W+1)'(bus.in_prod) + (ACC_W+1)'(BIAS);
`else
    logic unused_bias;
    assign unused_bias = ^BIAS;
    assign term        = (ACC_W+1)'(bus.in_prod);
`endif

    // acc_reg is zero in IDLE, so one adder serves both the first and later terms.
    assign sum_wide  = (ACC_W+2)'(acc_reg) + (ACC_W+2)'(term);
    assign add_carry = |sum_wide[ACC_W+1:ACC_W];
    assign ovf_next  = ovf_reg | add_carry | sat_hit;

    approx_mac_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept && bus.in_last),
        .en         (accept),
        .count_next (cnt_next),
        .sat_hit    (sat_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            sum_reg     <= '0;
            count_reg   <= '0;
            ovf_out_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (bus.in_last) begin
                            sum_reg     <= sum_wide[ACC_W-1:0];
                            count_reg   <= cnt_next;
                            ovf_out_reg <= ovf_next;
                            valid_reg   <= 1'b1;
                            acc_reg     <= '0;
                            ovf_reg     <= 1'b0;
                            state_reg   <= DONE;
                        end else begin
                            acc_reg   <= sum_wide[ACC_W-1:0];
                            ovf_reg   <= ovf_next;
                            state_reg <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg != DONE);
    assign bus.out_valid = valid_reg;
    assign bus.out_sum   = sum_reg;
    assign bus.out_count = count_reg;
    assign bus.out_ovf   = ovf_out_reg;
endmodule

// File: tb/tb_approx_mac_accumulator.sv
// Bench for approx_mac_accumulator: two instances (24/8 and 16/2 widths) share one stimulus.
module tb_approx_mac_accumulator;

`ifdef APPROX_BIAS_COMP_EN
    localparam longint TERM_BIAS = 3;
`else
    localparam longint TERM_BIAS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_prod = '0;

    always #5 clk = ~clk;

    approx_mac_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus_a ();
    approx_mac_accumulator_if #(.PROD_W(16), .ACC_W(16), .CNT_W(2)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_prod   = in_prod;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_prod   = in_prod;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    approx_mac_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8), .BIAS(16'd3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    approx_mac_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(2), .BIAS(16'd3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        longint sum;
        longint cnt;
        longint ovf;
    } res_t;

    typedef struct {
        int     n;
        int     prod [5];
        longint sum_a, cnt_a, ovf_a, sum_b, cnt_b, ovf_b;
    } vec_t;

    res_t   exp_a, exp_b;
    bit     exp_valid;
    longint cur_total;
    int     cur_n;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_pkt = 0;
    vec_t   tbl [$];

    // Packet result from the totals: wraps happened iff the total reaches 2^acc_w.
    function automatic res_t ref_result(input longint total, input int n, input int acc_w, input int cnt_w);
        res_t   r;
        longint cnt_max = (longint'(1) << cnt_w) - 1;
        longint modv    = longint'(1) << acc_w;
        r.sum = total % modv;
        r.cnt = (n > cnt_max) ? cnt_max : n;
        r.ovf = (total >= modv || n > cnt_max) ? 1 : 0;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_all();
        cmp("in_ready_a",  64'(bus_a.in_ready),  64'(!exp_valid));
        cmp("in_ready_b",  64'(bus_b.in_ready),  64'(!exp_valid));
        cmp("out_valid_a", 64'(bus_a.out_valid), 64'(exp_valid));
        cmp("out_valid_b", 64'(bus_b.out_valid), 64'(exp_valid));
        cmp("sum_a",   64'(bus_a.out_sum),   exp_a.sum);
        cmp("count_a", 64'(bus_a.out_count), exp_a.cnt);
        cmp("ovf_a",   64'(bus_a.out_ovf),   exp_a.ovf);
        cmp("sum_b",   64'(bus_b.out_sum),   exp_b.sum);
        cmp("count_b", 64'(bus_b.out_count), exp_b.cnt);
        cmp("ovf_b",   64'(bus_b.out_ovf),   exp_b.ovf);
    endtask

    // One clock: decide handshakes from the model, advance, then compare at +1.
    task automatic cycle(output bit fired_in);
        bit fi, fo;
        fi = rst_n && in_valid && !exp_valid;
        fo = rst_n && exp_valid && out_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_a = '{0, 0, 0};
            exp_b = '{0, 0, 0};
            exp_valid = 0;
            cur_total = 0;
            cur_n = 0;
        end else begin
            if (fo) exp_valid = 0;
            if (fi) begin
                cur_total += longint'(in_prod) + TERM_BIAS;
                cur_n++;
                if (in_last) begin
                    exp_a = ref_result(cur_total, cur_n, 24, 8);
                    exp_b = ref_result(cur_total, cur_n, 16, 2);
                    exp_valid = 1;
                    n_pkt++;
                    $display("pkt %0d: terms=%0d sum_a=%0d cnt_a=%0d ovf_a=%0d sum_b=%0d cnt_b=%0d ovf_b=%0d",
                             n_pkt, cur_n, exp_a.sum, exp_a.cnt, exp_a.ovf, exp_b.sum, exp_b.cnt, exp_b.ovf);
                    cur_total = 0;
                    cur_n = 0;
                end
            end
        end
        check_all();
        fired_in = fi;
    endtask

    task automatic send_beat(input logic [15:0] p, input bit last, input bit rand_ready);
        bit f;
        bit done;
        done = 0;
        in_valid = 1;
        in_prod  = p;
        in_last  = last;
        for (int k = 0; k < 200 && !done; k++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            cycle(f);
            done = f;
        end
        if (!done) cmp("beat_timeout", 64'd0, 64'd1);
        in_valid = 0;
        in_prod  = 16'($urandom);
        in_last  = 1'($urandom_range(0, 1));
    endtask

    function automatic void add_vec(input int n, input int p0, input int p1, input int p2, input int p3, input int p4,
                                    input longint sa, input longint ca, input longint oa,
                                    input longint sb, input longint cb, input longint ob);
        vec_t v;
        v.n = n;
        v.prod[0] = p0; v.prod[1] = p1; v.prod[2] = p2; v.prod[3] = p3; v.prod[4] = p4;
        v.sum_a = sa; v.cnt_a = ca; v.ovf_a = oa;
        v.sum_b = sb; v.cnt_b = cb; v.ovf_b = ob;
        tbl.push_back(v);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          f;
        int          len;
        logic [15:0] v;

`ifdef APPROX_BIAS_COMP_EN
        add_vec(2, 10, 20, 0, 0, 0,        36, 2, 0,    36, 2, 0);
        add_vec(1, 5, 0, 0, 0, 0,           8, 1, 0,     8, 1, 0);
        add_vec(2, 65535, 2, 0, 0, 0,   65543, 2, 0,     7, 2, 1);
`else
        add_vec(3, 100, 200, 300, 0, 0,   600, 3, 0,   600, 3, 0);
        add_vec(1, 65025, 0, 0, 0, 0,   65025, 1, 0, 65025, 1, 0);
        add_vec(2, 65535, 2, 0, 0, 0,   65537, 2, 0,     1, 2, 1);
        add_vec(1, 5, 0, 0, 0, 0,           5, 1, 0,     5, 1, 0);
        add_vec(5, 1, 1, 1, 1, 1,           5, 5, 0,     5, 3, 1);
        add_vec(4, 1000, 2000, 3000, 4000, 0, 10000, 4, 0, 10000, 3, 1);
        add_vec(2, 40000, 40000, 0, 0, 0, 80000, 2, 0, 14464, 2, 1);
`endif

        // Reset state
        rst_n = 0;
        cycle(f);
        cycle(f);
        rst_n = 1;
        cycle(f);
        cmp("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        cmp("rst_out_sum",   64'(bus_a.out_sum),   64'd0);
        cmp("rst_in_ready",  64'(bus_a.in_ready),  64'd1);

        // Table-driven packets, back to back with out_ready held high
        out_ready = 1;
        foreach (tbl[t]) begin
            for (int i = 0; i < tbl[t].n; i++)
                send_beat(16'(tbl[t].prod[i]), i == tbl[t].n - 1, 1'b0);
            cmp("tbl_valid_a", 64'(bus_a.out_valid), 64'd1);
            cmp("tbl_sum_a",   64'(bus_a.out_sum),   tbl[t].sum_a);
            cmp("tbl_count_a", 64'(bus_a.out_count), tbl[t].cnt_a);
            cmp("tbl_ovf_a",   64'(bus_a.out_ovf),   tbl[t].ovf_a);
            cmp("tbl_sum_b",   64'(bus_b.out_sum),   tbl[t].sum_b);
            cmp("tbl_count_b", 64'(bus_b.out_count), tbl[t].cnt_b);
            cmp("tbl_ovf_b",   64'(bus_b.out_ovf),   tbl[t].ovf_b);
        end
        cycle(f);

        // Backpressure: result held while the next beat waits
        out_ready = 0;
        send_beat(16'd7, 1'b0, 1'b0);
        send_beat(16'd8, 1'b1, 1'b0);
        in_valid = 1;
        in_prod  = 16'd9;
        in_last  = 1;
        repeat (5) begin
            cycle(f);
            cmp("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
            cmp("bp_sum_hold", 64'(bus_a.out_sum),  64'(15 + 2 * TERM_BIAS));
        end
        out_ready = 1;
        cycle(f);
        cmp("bp_ready_back", 64'(bus_a.in_ready),  64'd1);
        cmp("bp_valid_drop", 64'(bus_a.out_valid), 64'd0);
        cycle(f);
        cmp("bp_next_valid", 64'(bus_a.out_valid), 64'd1);
        cmp("bp_next_sum",   64'(bus_a.out_sum),   64'(9 + TERM_BIAS));
        in_valid = 0;
        cycle(f);

        // Reset mid-packet discards the partial sum
        send_beat(16'd10, 1'b0, 1'b0);
        send_beat(16'd20, 1'b0, 1'b0);
        rst_n = 0;
        cycle(f);
        rst_n = 1;
        cmp("mid_rst_sum",   64'(bus_a.out_sum),   64'd0);
        cmp("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
        send_beat(16'd7, 1'b1, 1'b0);
        cmp("post_rst_sum_a",   64'(bus_a.out_sum),   64'(7 + TERM_BIAS));
        cmp("post_rst_count_a", 64'(bus_a.out_count), 64'd1);
        cmp("post_rst_sum_b",   64'(bus_b.out_sum),   64'(7 + TERM_BIAS));
        cmp("post_rst_ovf_b",   64'(bus_b.out_ovf),   64'd0);
        cycle(f);

        // Randomized packets with idle gaps and random backpressure
        for (int p = 0; p < 150; p++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) v = 16'hFFFF - 16'($urandom_range(0, 255));
                else v = 16'($urandom);
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    in_valid  = 0;
                    in_prod   = 16'($urandom);
                    out_ready = 1'($urandom_range(0, 1));
                    cycle(f);
                end
                send_beat(v, i == len - 1, 1'b1);
            end
        end

        in_valid  = 0;
        out_ready = 1;
        repeat (3) cycle(f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/approx_mac_accumulator.md
Name: approx_mac_accumulator

Overview:
- Downstream stage of the unsigned 8x8 approximate multipliers; consumes their 16-bit product stream and accumulates a dot product over a packet of terms.
- Valid/ready on both sides; one registered result per packet (sum, term count, overflow flag) is held until accepted.
- Feeds error-metric collection and the accumulate path of approximate-MAC experiments.

Parameters:
- PROD_W, 16, width of incoming product (multiplier z output).
- ACC_W, 24, accumulator/result width; must be >= PROD_W.
- CNT_W, 8, term-counter width; counter saturates at 2^CNT_W-1.
- BIAS, 0, unsigned per-term compensation constant, PROD_W bits; used only with the optional feature.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  stage accepts a beat.
- in_prod  in  PROD_W  product from multiplier (z).
- in_last  in  1  beat is final term of packet.
- out_valid  out  1  packet result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  accumulated sum.
- out_count  out  CNT_W  number of terms accepted in packet (saturating).
- out_ovf  out  1  sticky: sum wrapped or count saturated during packet.

Behaviour:
- Reset (rst_n=0 sampled on clk edge): state=IDLE, acc=0, cnt=0, ovf=0; out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=1 the cycle after reset releases. Reset mid-packet discards the partial sum; a held result is dropped.
- Beat accepted when in_valid & in_ready. Term value t = zero-extended in_prod (plus BIAS if feature on), zero-extended to ACC_W+1.
- States: IDLE (acc empty), ACCUM (>=1 term taken), DONE (result held).
- IDLE: accept -> if in_last go DONE with sum=t, count=1; else ACCUM with acc=t, cnt=1.
- ACCUM: accept -> acc_next = (acc + t) mod 2^ACC_W; carry out of bit ACC_W-1 sets ovf. cnt increments, saturating at max; an increment attempted at max sets ovf. in_last -> DONE, else stay.
- Entering DONE: out_sum/out_count/out_ovf register the final values, out_valid=1 the next cycle (latency 1 cycle from the last accepted beat). acc/cnt/ovf clear.
- DONE: in_ready=0; outputs stable while out_valid & !out_ready. On out_ready -> IDLE, out_valid=0 next cycle, in_ready=1 next cycle (one bubble per packet; no bypass).
- in_ready = (state != DONE). It is registered-state-derived only, with no combinational path from out_ready.
- in_valid with in_last on a single-term packet is legal. in_prod is ignored when in_valid=0. Output fields are don't-care-free: they hold their last values while out_valid=0.

Optional Feature:
- Macro APPROX_BIAS_COMP_EN.
- Defined: each accepted term adds BIAS before accumulation. This compensates the mean under-estimate of truncated/approximate multipliers. Bias contributes to overflow detection.
- Undefined: BIAS is ignored; t = in_prod exactly; no adder for the bias is present.

Decomposition:
- Shared package approx_mac_pkg: state enum (IDLE/ACCUM/DONE), default widths PROD_W/ACC_W/CNT_W, the function computing saturating counter increment.
- One natural sub-module: approx_mac_sat_counter (CNT_W-bit saturating counter with clear, enable, saturate-hit flag).
- Accumulator adder stays inline.

Test Plan:
- Reset then packet {100, 200, 300(last)}, out_ready=1 -> 1 cycle after the last beat: out_valid=1, out_sum=600, out_count=3, out_ovf=0; in_ready low for exactly that DONE cycle.
- Single-term packet 65025(last) -> out_sum=65025, out_count=1, out_ovf=0.
- ACC_W=16, packet {65535, 2(last)} -> out_sum=1, out_ovf=1. The next packet {5(last)} -> out_sum=5, out_ovf=0 (sticky cleared per packet).
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> accepted, in_ready=1 next cycle, no beat lost.
- CNT_W=2, 5-term packet of 1s -> out_count=3, out_sum=5, out_ovf=1.
- rst_n=0 mid-packet after {10, 20} then packet {7(last)} -> out_sum=7, out_count=1. With APPROX_BIAS_COMP_EN and BIAS=3, packet {10, 20(last)} -> out_sum=36.
